// File: rtl/axil_regfile_pkg.sv
// Shared response codes, FSM state types and address decode for the AXI-Lite register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_A, WR_HAVE_D, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // Word index of a byte address; the two byte-offset bits are ignored.
  function automatic logic [31:0] reg_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/axil_regfile_wr_fsm.sv
// AXI-Lite write channel: independent AW/W capture, single outstanding write, B response.
module axil_regfile_wr_fsm
  import axil_regfile_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                commit,
  output logic                commit_ok,
  output logic [31:0]         commit_idx,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W/8-1:0] commit_strb
);

  wr_state_t             state;
  logic                  have_a, have_d;
  logic                  a_next, d_next;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   strb_q;

  assign awready     = !areset && !have_a && (state != WR_RESP);
  assign wready      = !areset && !have_d && (state != WR_RESP);
  assign a_next      = have_a || (awvalid && awready);
  assign d_next      = have_d || (wvalid && wready);
  assign commit      = have_a && have_d;
  assign commit_idx  = reg_index(32'(addr_q));
  assign commit_ok   = commit_idx < 32'(NUM_REGS);
  assign commit_data = data_q;
  assign commit_strb = strb_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= WR_IDLE;
      have_a <= 1'b0;
      have_d <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else begin
      case (state)
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= WR_IDLE;
          end
        end
        default: begin
          if (commit) begin
            have_a <= 1'b0;
            have_d <= 1'b0;
            bvalid <= 1'b1;
            bresp  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            state  <= WR_RESP;
          end else begin
            if (awvalid && awready) addr_q <= awaddr;
            if (wvalid && wready) begin
              data_q <= wdata;
              strb_q <= wstrb;
            end
            have_a <= a_next;
            have_d <= d_next;
            // With both halves held the commit fires next cycle; the label stays WR_HAVE_A.
            if (a_next)      state <= WR_HAVE_A;
            else if (d_next) state <= WR_HAVE_D;
            else             state <= WR_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI-Lite slave register file with read path and storage; define AXIL_REGFILE_WSTRB_EN to honour wstrb.
module axil_regfile_slave
  import axil_regfile_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W-1:0]        s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [DATA_W-1:0]        s_axil_wdata,
  input  logic [DATA_W/8-1:0]      s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [ADDR_W-1:0]        s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [DATA_W-1:0]        s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  logic                commit, commit_ok;
  logic [31:0]         commit_idx, rd_idx;
  logic [DATA_W-1:0]   commit_data, cur_word, wr_word, rd_word;
  logic [DATA_W/8-1:0] commit_strb;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  rd_state_t           rd_state;

  axil_regfile_wr_fsm #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_wr_fsm (
    .aclk       (aclk),
    .areset     (areset),
    .awaddr     (s_axil_awaddr),
    .awvalid    (s_axil_awvalid),
    .awready    (s_axil_awready),
    .wdata      (s_axil_wdata),
    .wstrb      (s_axil_wstrb),
    .wvalid     (s_axil_wvalid),
    .wready     (s_axil_wready),
    .bresp      (s_axil_bresp),
    .bvalid     (s_axil_bvalid),
    .bready     (s_axil_bready),
    .commit     (commit),
    .commit_ok  (commit_ok),
    .commit_idx (commit_idx),
    .commit_data(commit_data),
    .commit_strb(commit_strb)
  );

  assign rd_idx         = reg_index(32'(s_axil_araddr));
  assign s_axil_arready = !areset && (rd_state == RD_IDLE);

  always_comb begin
    cur_word = '0;
    rd_word  = '0;
    reg_q    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit_idx == i) cur_word = regs[i];
      if (rd_idx == i)     rd_word  = regs[i];
      reg_q[i*DATA_W +: DATA_W] = regs[i];
    end
  end

`ifdef AXIL_REGFILE_WSTRB_EN
  always_comb begin
    wr_word = cur_word;
    for (int unsigned k = 0; k < DATA_W/8; k++) begin
      if (commit_strb[k]) wr_word[k*8 +: 8] = commit_data[k*8 +: 8];
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^{commit_strb, cur_word};
  assign wr_word     = commit_data;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse  <= '0;
      rd_state      <= RD_IDLE;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit && commit_ok && commit_idx == i) begin
          regs[i]         <= wr_word;
          reg_wr_pulse[i] <= 1'b1;
        end
      end
      // Read data samples regs before this edge's write lands, so a colliding read sees the old value.
      case (rd_state)
        RD_IDLE: begin
          if (s_axil_arvalid) begin
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= (rd_idx < 32'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
            s_axil_rvalid <= 1'b1;
            rd_state      <= RD_RESP;
          end
        end
        default: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            rd_state      <= RD_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Randomised self-checking bench for axil_regfile_slave against an array-based register model.
module tb_axil_regfile_slave;

  localparam int NR = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic [11:0]   awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  axil_regfile_slave #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(NR)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx < NR) begin
`ifdef AXIL_REGFILE_WSTRB_EN
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
`else
      if (strb !== 4'bxxxx) model[idx] = data;
`endif
    end
  endfunction

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_hold);
    int cyc;
    bit aw_done, w_done, aw_now, w_now;
    int idx;
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_pulse;
    idx = int'(addr) / 4;
    exp_resp  = (idx < NR) ? 2'b00 : 2'b10;
    exp_pulse = (idx < NR) ? (NR'(1) << idx) : '0;
    cyc = 0; aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      step();
      cyc++;
      if (aw_now) aw_done = 1;
      if (w_now) w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    tests++;
    if (!(aw_done && w_done)) begin
      fails++; $display("FAIL wr_handshake addr=%h aw=%0d w=%0d required both", addr, aw_done, w_done);
    end
    tests++;
    if (bvalid !== 1'b0) begin
      fails++; $display("FAIL wr_early_bvalid got %b required 0", bvalid);
    end
    model_write(addr, data, strb);
    step();
    tests++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      fails++; $display("FAIL wr_bresp addr=%h got v=%b r=%b required v=1 r=%b", addr, bvalid, bresp, exp_resp);
    end
    tests++;
    if (reg_q !== model_flat()) begin
      fails++; $display("FAIL wr_reg_q addr=%h got %h required %h", addr, reg_q, model_flat());
    end
    tests++;
    if (reg_wr_pulse !== exp_pulse) begin
      fails++; $display("FAIL wr_pulse got %b required %b", reg_wr_pulse, exp_pulse);
    end
    for (int h = 0; h < b_hold; h++) begin
      step();
      tests++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0
          || reg_wr_pulse !== '0) begin
        fails++;
        $display("FAIL wr_hold got v=%b r=%b awr=%b wr=%b p=%b required v=1 r=%b awr=0 wr=0 p=0",
                 bvalid, bresp, awready, wready, reg_wr_pulse, exp_resp);
      end
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    tests++;
    if (bvalid !== 1'b0 || reg_wr_pulse !== '0 || awready !== 1'b1 || wready !== 1'b1) begin
      fails++;
      $display("FAIL wr_b_done got v=%b p=%b awr=%b wr=%b required v=0 p=0 awr=1 wr=1",
               bvalid, reg_wr_pulse, awready, wready);
    end
  endtask

  task automatic do_read(input logic [11:0] addr, input int r_hold);
    int cyc, idx;
    bit hs, ar_now;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx = int'(addr) / 4;
    exp_data = (idx < NR) ? model[idx] : 32'h0;
    exp_resp = (idx < NR) ? 2'b00 : 2'b10;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    cyc = 0; hs = 0;
    while (!hs && cyc < 20) begin
      ar_now = arready;
      step();
      cyc++;
      hs = ar_now;
    end
    arvalid = 1'b0;
    tests++;
    if (!hs || rvalid !== 1'b1) begin
      fails++; $display("FAIL rd_latency addr=%h hs=%0d rvalid=%b required hs=1 rvalid=1", addr, hs, rvalid);
    end
    tests++;
    if (rdata !== exp_data || rresp !== exp_resp) begin
      fails++; $display("FAIL rd_data addr=%h got %h/%b required %h/%b", addr, rdata, rresp, exp_data, exp_resp);
    end
    for (int h = 0; h < r_hold; h++) begin
      step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
        fails++;
        $display("FAIL rd_hold got v=%b d=%h r=%b arr=%b required v=1 d=%h r=%b arr=0",
                 rvalid, rdata, rresp, arready, exp_data, exp_resp);
      end
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    tests++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      fails++; $display("FAIL rd_done got rvalid=%b arready=%b required 0/1", rvalid, arready);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) step();
    tests++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00
        || rdata !== 32'h0 || reg_q !== '0 || reg_wr_pulse !== '0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b%b%b v=%b%b br=%b rr=%b rd=%h p=%b required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse);
    end
    areset = 1'b0;
    step();
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL reset_release got %b%b%b required 111", awready, wready, arready);
    end
  endtask

  task automatic test_same_cycle();
    do_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    tests++;
    if (reg_q[63:32] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL same_cycle_reg1 got %h required deadbeef", reg_q[63:32]);
    end
  endtask

  task automatic test_w_first();
    do_write(12'h008, 32'h12345678, 4'hF, 3, 0, 0);
    tests++;
    if (reg_q[95:64] !== 32'h12345678) begin
      fails++; $display("FAIL w_first_reg2 got %h required 12345678", reg_q[95:64]);
    end
    do_write(12'h00A, 32'hCAFEF00D, 4'hF, 0, 2, 0);
    do_read(12'h008, 0);
  endtask

  task automatic test_out_of_range();
    do_read(12'h040, 0);
    do_write(12'h040, $urandom, 4'hF, 0, 0, 0);
    do_read(12'hFFC, 1);
  endtask

  task automatic test_backpressure();
    do_write(12'h00C, 32'hA5A55A5A, 4'hF, 1, 0, 5);
    do_read(12'h00C, 5);
  endtask

  task automatic test_wstrb();
    logic [31:0] exp;
`ifdef AXIL_REGFILE_WSTRB_EN
    exp = 32'hFF00FF00;
`else
    exp = 32'h00000000;
`endif
    do_write(12'h000, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(12'h000, 32'h00000000, 4'b0101, 0, 0, 0);
    tests++;
    if (reg_q[31:0] !== exp) begin
      fails++; $display("FAIL wstrb_reg0 got %h required %h", reg_q[31:0], exp);
    end
    do_read(12'h000, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [11:0] a;
      a = 12'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    hs = 0;
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (arready) hs++;
      step();
      if (rvalid && rdata !== model[1]) begin
        tests++; fails++;
        $display("FAIL b2b_rdata got %h required %h", rdata, model[1]);
      end
    end
    arvalid = 1'b0; rready = 1'b0;
    tests++;
    if (hs != 10) begin
      fails++; $display("FAIL b2b_read_rate got %0d required 10", hs);
    end
    hs = 0;
    awaddr = 12'h018; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (awready && wready) hs++;
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) step();
    bready = 1'b0;
    model_write(12'h018, 32'h0BADF00D, 4'hF);
    tests++;
    if (hs != 10) begin
      fails++; $display("FAIL b2b_write_rate got %0d required 10", hs);
    end
    tests++;
    if (reg_q !== model_flat()) begin
      fails++; $display("FAIL b2b_reg_q got %h required %h", reg_q, model_flat());
    end
  endtask

  task automatic test_reset_abort();
    bit seen_b;
    awaddr = 12'h014; awvalid = 1'b1; wvalid = 1'b0;
    tests++;
    if (awready !== 1'b1) begin
      fails++; $display("FAIL abort_awready got %b required 1", awready);
    end
    step();
    awvalid = 1'b0;
    step();
    areset = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    step();
    tests++;
    if ({awready, wready, arready, bvalid} !== 4'b0) begin
      fails++; $display("FAIL abort_in_reset got %b%b%b%b required 0000", awready, wready, arready, bvalid);
    end
    areset = 1'b0;
    wdata = 32'h55AA55AA; wvalid = 1'b0; bready = 1'b1;
    seen_b = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bvalid) seen_b = 1;
    end
    bready = 1'b0;
    tests++;
    if (seen_b) begin
      fails++; $display("FAIL abort_bvalid got bvalid=1 required none");
    end
    tests++;
    if (reg_q !== model_flat() || {awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL abort_after got q=%h rdy=%b%b%b required q=0 rdy=111",
                        reg_q, awready, wready, arready);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_out_of_range();
    test_backpressure();
    test_wstrb();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
